// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared timing constants, types and writer states for the
//            framebuffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_START    = 144;
  localparam int V_START    = 35;
  localparam int H_DISPLAY  = 640;
  localparam int V_DISPLAY  = 480;
  localparam int CELL_SHIFT = 3;
  localparam int COLS       = H_DISPLAY >> CELL_SHIFT;
  localparam int ROWS       = V_DISPLAY >> CELL_SHIFT;
  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 13;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] cell_addr_t;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } w_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter_if
// Brief    : Writer req/ack bus; master is the writer, slave the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int PIX_W  = vga_pkg::PIX_W
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ack;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );

endinterface
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_delay
// Brief    : N-stage delay line for {h_sync, v_sync, blank_n, sync_n}.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sync_in,
  output logic [3:0] sync_out
);

  logic [N-1:0][3:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= sync_in;
      for (int i = 1; i < N; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign sync_out = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Brief    : Shares a 1-cycle-latency framebuffer RAM between VGA scanout
//            (always wins) and a single req/ack writer.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int H_START    = vga_pkg::H_START,
  parameter int V_START    = vga_pkg::V_START,
  parameter int CELL_SHIFT = vga_pkg::CELL_SHIFT,
  parameter int COLS       = vga_pkg::COLS,
  parameter int ROWS       = vga_pkg::ROWS,
  parameter int PIX_W      = vga_pkg::PIX_W,
  parameter int ADDR_W     = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              blank_n_in,
  input  logic              sync_n_in,
  input  logic [9:0]        posx,
  input  logic [9:0]        posy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  vga_fb_arbiter_if.slave   wr,
  output logic              h_sync,
  output logic              v_sync,
  output logic              blank_n,
  output logic              sync_n,
  output logic [PIX_W-1:0]  pix_out,
  output logic              frame_start
);

  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] c_cell_count = ADDR_W'(COLS * ROWS);

  logic [9:0]        w_col_off;
  logic [9:0]        w_row_off;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_claim;
  logic              w_grant;
  logic              w_in_range;
  logic [3:0]        w_sync_d2;

  w_state_t          r_w_state;
  logic              r_wr_ack;
  logic              r_rd_pend;
  logic [PIX_W-1:0]  r_cell;
  logic              r_frame_start;

  // Offsets are garbage in the porches; blank_n_in gates every use of them.
  assign w_col_off   = posx - 10'(H_START);
  assign w_row_off   = posy - 10'(V_START);
  assign w_claim     = blank_n_in && (w_col_off[CELL_SHIFT-1:0] == '0);
  assign w_scan_addr = ADDR_W'(w_row_off >> CELL_SHIFT) * ADDR_W'(COLS)
                     + ADDR_W'(w_col_off >> CELL_SHIFT);

  assign w_grant    = (r_w_state == W_IDLE) && wr.wr_req && !w_claim;
  assign w_in_range = wr.wr_addr < c_cell_count;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_claim) begin
      mem_addr = w_scan_addr;
    end else if (w_grant) begin
      mem_addr  = wr.wr_addr;
      mem_wdata = wr.wr_data;
      mem_we    = w_in_range && !rst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_state <= W_IDLE;
      r_wr_ack  <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_grant) begin
            r_w_state <= W_ACK;
            r_wr_ack  <= 1'b1;
          end
        end
        W_ACK: begin
          r_w_state <= W_IDLE;
          r_wr_ack  <= 1'b0;
        end
      endcase
    end
  end

  // RAM data lands one cycle after the claim; the cell then holds for the
  // remaining pixels of the cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend     <= 1'b0;
      r_cell        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_rd_pend     <= w_claim;
      r_frame_start <= (posx == 10'd0) && (posy == 10'd0);
      if (r_rd_pend) begin
        r_cell <= mem_rdata;
      end
    end
  end

  vga_sync_delay #(
    .N (2)
  ) u_sync_delay (
    .clk      (clk),
    .rst      (rst),
    .sync_in  ({h_sync_in, v_sync_in, blank_n_in, sync_n_in}),
    .sync_out (w_sync_d2)
  );

  assign h_sync      = w_sync_d2[3];
  assign v_sync      = w_sync_d2[2];
  assign blank_n     = w_sync_d2[1];
  assign sync_n      = w_sync_d2[0];
  assign pix_out     = w_sync_d2[1] ? r_cell : '0;
  assign wr.wr_ack   = r_wr_ack;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire
